// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - FIFO-buffered UART transmitter with optional parity and one or two stop bits
module uart_tx_framed #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       data,
   input  logic                        valid,
   output logic                        ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = AW + 1;
   localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [CW-1:0]    LAST_TICK = CW'(BIT_CYCLES - 1);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_WIDTH - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CNT_W-1:0]      count_q;

   state_t                state_q, state_d;
   logic [CW-1:0]         tick_q, tick_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;

   logic                  push;
   logic                  pop;
   logic                  start_frame;
   logic                  bit_done;
   logic [DATA_WIDTH-1:0] head;
   logic                  head_par;

   // ready depends only on occupancy; writes are suppressed while in reset
   assign ready      = (count_q != FULL_CNT);
   assign push       = valid && ready && !rst;
   assign head       = mem[rd_ptr];
   assign head_par   = (PARITY == 2) ? ~(^head) : ^head;
   assign bit_done   = (tick_q == LAST_TICK);
   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE) || (count_q != '0);
   assign fifo_count = count_q;

   // FIFO storage array, written on accepted words
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Frame state register, baud/bit counters, shift register and registered line
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic; tx_d is the value the line takes after this edge
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q + CW'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_d       = par_q;
      tx_d        = tx_q;
      pop         = 1'b0;
      start_frame = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            tx_d   = 1'b1;
            if (count_q != '0) begin
               start_frame = 1'b1;
            end
         end
         ST_START: begin
            if (bit_done) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               tick_d = '0;
               if (bit_q == LAST_DATA) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               tick_d = '0;
               if (bit_q == LAST_STOP) begin
                  bit_d = '0;
                  if (count_q != '0) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase

      // Back-to-back frames share this path with the idle start: pop, latch, drive start bit
      if (start_frame) begin
         pop     = 1'b1;
         state_d = ST_START;
         tick_d  = '0;
         bit_d   = '0;
         shift_d = head;
         par_d   = head_par;
         tx_d    = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - directed self-checking bench for uart_tx_framed
module tb_uart_tx_framed;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] data;

   logic       rdy_p0, tx_p0, busy_p0;
   logic [2:0] cnt_p0;
   logic       rdy_pe, tx_pe, busy_pe;
   logic [4:0] cnt_pe;
   logic       rdy_po, tx_po, busy_po;
   logic [4:0] cnt_po;
   logic       rdy_s2, tx_s2, busy_s2;
   logic [4:0] cnt_s2;

   int n_tests = 0;
   int n_fail  = 0;

   logic tx_log   [4][0:599];
   logic busy_log [4][0:599];

   always #5 clk = ~clk;

   uart_tx_framed #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_p0 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(rdy_p0),
      .tx(tx_p0), .busy(busy_p0), .fifo_count(cnt_p0));

   uart_tx_framed #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_pe (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(rdy_pe),
      .tx(tx_pe), .busy(busy_pe), .fifo_count(cnt_pe));

   uart_tx_framed #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_po (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(rdy_po),
      .tx(tx_po), .busy(busy_po), .fifo_count(cnt_po));

   uart_tx_framed #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_s2 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(rdy_s2),
      .tx(tx_s2), .busy(busy_s2), .fifo_count(cnt_s2));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic record(input int c);
      tx_log[0][c]   = tx_p0;   busy_log[0][c] = busy_p0;
      tx_log[1][c]   = tx_pe;   busy_log[1][c] = busy_pe;
      tx_log[2][c]   = tx_po;   busy_log[2][c] = busy_po;
      tx_log[3][c]   = tx_s2;   busy_log[3][c] = busy_s2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
   endtask

   // Line waveform: each character of s is one bit held 10 cycles, idle-high after
   function automatic logic [127:0] wave(input string s, input int n);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < n; i++) begin
         if (i / 10 < s.len()) w[i] = (s.substr(i / 10, i / 10) == "1");
         else                  w[i] = 1'b1;
      end
      return w;
   endfunction

   function automatic logic [127:0] ones(input int k, input int n);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w[i] = (i < k);
      return w;
   endfunction

   function automatic logic [127:0] grab_tx(input int k, input int start, input int n);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = tx_log[k][start + i];
      return v;
   endfunction

   function automatic logic [127:0] grab_busy(input int k, input int start, input int n);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = busy_log[k][start + i];
      return v;
   endfunction

   initial begin
      string q4 [4];
      string q5 [5];
      int    viol;

      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      do_reset();

      @(negedge clk);
      check("reset_tx", tx_p0, 1'b1);
      check("reset_busy", busy_p0, 1'b0);
      check("reset_ready", rdy_p0, 1'b1);
      check("reset_count", cnt_p0, 3'd0);

      // 0xA5 through no-parity, even and odd instances
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         record(c);
         if (c == 1) begin
            check("a5_count_after_push", cnt_p0, 3'd1);
            check("a5_tx_idle_before_start", tx_p0, 1'b1);
         end
         valid = (c == 0);
         data  = 8'hA5;
      end
      check("a5_p0_tx", grab_tx(0, 2, 120), wave("0101001011", 120));
      check("a5_p0_busy", grab_busy(0, 2, 120), ones(100, 120));
      check("a5_even_tx", grab_tx(1, 2, 120), wave("01010010101", 120));
      check("a5_even_busy", grab_busy(1, 2, 120), ones(110, 120));
      check("a5_odd_tx", grab_tx(2, 2, 120), wave("01010010111", 120));

      // 0x00 with two stop bits
      do_reset();
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         record(c);
         valid = (c == 0);
         data  = 8'h00;
      end
      check("zero_2stop_tx", grab_tx(3, 2, 120), wave("00000000011", 120));
      check("zero_2stop_busy", grab_busy(3, 2, 120), ones(110, 120));
      check("zero_1stop_tx", grab_tx(0, 2, 120), wave("0000000001", 120));

      // Simultaneous push and pop at occupancy 2
      do_reset();
      q4[0] = "0100010001";
      q4[1] = "0010001001";
      q4[2] = "0110011001";
      q4[3] = "0001000101";
      for (int c = 0; c < 420; c++) begin
         @(negedge clk);
         record(c);
         if (c == 101) check("pp_count_before", cnt_p0, 3'd2);
         if (c == 102) check("pp_count_same_edge", cnt_p0, 3'd2);
         if (c == 103) check("pp_count_after", cnt_p0, 3'd2);
         valid = (c < 3) || (c == 101);
         case (c)
            0:       data = 8'h11;
            1:       data = 8'h22;
            2:       data = 8'h33;
            default: data = 8'h44;
         endcase
      end
      for (int f = 0; f < 4; f++) begin
         check($sformatf("pp_frame%0d", f), grab_tx(0, 2 + 100 * f, 100), wave(q4[f], 100));
      end
      check("pp_tail_tx", grab_tx(0, 402, 10), ones(10, 10));
      check("pp_tail_busy", grab_busy(0, 402, 10), ones(0, 10));

      // Depth-4 FIFO overfill: five accepted words, two blocked attempts
      do_reset();
      q5[0] = "0100000001";
      q5[1] = "0010000001";
      q5[2] = "0110000001";
      q5[3] = "0001000001";
      q5[4] = "0101000001";
      for (int c = 0; c < 530; c++) begin
         @(negedge clk);
         record(c);
         if (c == 1) begin
            check("full_c1_count", cnt_p0, 3'd1);
            check("full_c1_ready", rdy_p0, 1'b1);
         end
         if (c == 2) begin
            check("full_c2_count", cnt_p0, 3'd1);
            check("full_c2_tx_start", tx_p0, 1'b0);
         end
         if (c == 4) check("full_c4_ready", rdy_p0, 1'b1);
         if (c == 5) begin
            check("full_c5_count", cnt_p0, 3'd4);
            check("full_c5_ready", rdy_p0, 1'b0);
         end
         if (c == 7) begin
            check("full_blocked_count", cnt_p0, 3'd4);
            check("full_blocked_tx", tx_p0, 1'b0);
            check("full_blocked_busy", busy_p0, 1'b1);
         end
         valid = (c <= 6);
         data  = 8'(c + 1);
      end
      for (int f = 0; f < 5; f++) begin
         check($sformatf("full_frame%0d", f), grab_tx(0, 2 + 100 * f, 100), wave(q5[f], 100));
      end
      check("full_tail_tx", grab_tx(0, 502, 10), ones(10, 10));
      check("full_tail_busy", grab_busy(0, 502, 10), ones(0, 10));

      // Mid-frame reset with three words queued; a word offered during reset is dropped
      do_reset();
      viol = 0;
      for (int c = 0; c < 350; c++) begin
         @(negedge clk);
         record(c);
         if (c == 38) begin
            check("rst_pre_count", cnt_p0, 3'd3);
            check("rst_pre_busy", busy_p0, 1'b1);
         end
         if (c == 39) begin
            check("rst_tx", tx_p0, 1'b1);
            check("rst_count", cnt_p0, 3'd0);
            check("rst_busy", busy_p0, 1'b0);
            check("rst_ready", rdy_p0, 1'b1);
         end
         if (c >= 40) begin
            if (tx_p0 !== 1'b1 || busy_p0 !== 1'b0 || cnt_p0 !== 3'd0) viol++;
         end
         rst   = (c == 38);
         valid = (c < 4) || (c == 38);
         data  = (c == 38) ? 8'hEE : 8'(8'h10 + c);
      end
      check("rst_no_more_frames", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
